// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU and load results into one write per
// cycle, queues the losers in an in-order FIFO and reports pending destinations.

module wb_pend_match (
  input  logic       vld,
  input  logic [4:0] ent_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = vld && (ent_rd == rs1);
  assign hit2 = vld && (ent_rd == rs2);
endmodule

module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            alu_valid_in,
  input  logic [4:0]      alu_rd_in,
  input  logic [XLEN-1:0] alu_data_in,
  input  logic            load_valid_in,
  input  logic [4:0]      load_rd_in,
  input  logic [XLEN-1:0] load_data_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  output logic            rd_write_signal_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] wr_data_out,
  output logic            stall_signal_out,
  output logic            rs1_pending_out,
  output logic            rs2_pending_out,
  output logic            overflow_error_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t          fifo_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_nxt;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q, wr_ptr_p1;
  logic [AW:0]      count_q, free_w;

  wb_ent_t load_ent, alu_ent, sel_ent;
  logic    has_h, has_l, has_a, sel_vld;
  logic    push_l, push_a, acc_l, acc_a, drop;

  assign load_ent  = '{rd: load_rd_in, data: load_data_in};
  assign alu_ent   = '{rd: alu_rd_in,  data: alu_data_in};
  assign has_h     = (count_q != '0);
  assign has_l     = load_valid_in && (load_rd_in != 5'd0);
  assign has_a     = alu_valid_in && (alu_rd_in != 5'd0);
  assign free_w    = DEPTH_C - count_q;
  assign wr_ptr_p1 = wr_ptr_q + 1'b1;

  // Age order: queued head, then load, then ALU. Free space ignores the same-cycle
  // pop, so a full-rate burst while stalled drops rather than relying on the drain.
  always_comb begin
    sel_vld = has_h || has_l || has_a;
    sel_ent = has_h ? fifo_q[rd_ptr_q] : (has_l ? load_ent : alu_ent);
    push_l  = has_l && has_h;
    push_a  = has_a && (has_h || has_l);
    acc_l   = push_l && (free_w >= (AW+1)'(1));
    acc_a   = push_a && (free_w >= (acc_l ? (AW+1)'(2) : (AW+1)'(1)));
    drop    = (push_l && !acc_l) || (push_a && !acc_a);
  end

  always_comb begin
    vld_nxt = vld_q;
    if (has_h) vld_nxt[rd_ptr_q] = 1'b0;
    if (acc_l) vld_nxt[wr_ptr_q] = 1'b1;
    if (acc_a) vld_nxt[acc_l ? wr_ptr_p1 : wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_q               <= '0;
      rd_ptr_q            <= '0;
      wr_ptr_q            <= '0;
      count_q             <= '0;
      overflow_error_out  <= 1'b0;
      rd_write_signal_out <= 1'b0;
      rd_out              <= '0;
      wr_data_out         <= '0;
    end else begin
      vld_q               <= vld_nxt;
      rd_ptr_q            <= rd_ptr_q + AW'(has_h);
      wr_ptr_q            <= wr_ptr_q + AW'(acc_l) + AW'(acc_a);
      count_q             <= count_q - (AW+1)'(has_h) + (AW+1)'(acc_l) + (AW+1)'(acc_a);
      rd_write_signal_out <= sel_vld;
      if (drop) overflow_error_out <= 1'b1;
      if (sel_vld) begin
        rd_out      <= sel_ent.rd;
        wr_data_out <= sel_ent.data;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by vld_q and count_q.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (acc_l) fifo_q[wr_ptr_q] <= load_ent;
      if (acc_a) fifo_q[acc_l ? wr_ptr_p1 : wr_ptr_q] <= alu_ent;
    end
  end

  assign stall_signal_out = (free_w < (AW+1)'(2));

  logic [DEPTH-1:0] hit1, hit2;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    wb_pend_match u_match (
      .vld   (vld_q[i]),
      .ent_rd(fifo_q[i].rd),
      .rs1   (rs1_in),
      .rs2   (rs2_in),
      .hit1  (hit1[i]),
      .hit2  (hit2[i])
    );
  end

  // The in-flight write stays pending until the register file's negedge write lands.
  assign rs1_pending_out = (rs1_in != 5'd0) &&
                           ((|hit1) || (rd_write_signal_out && (rd_out == rs1_in)));
  assign rs2_pending_out = (rs2_in != 5'd0) &&
                           ((|hit2) || (rd_write_signal_out && (rd_out == rs2_in)));

endmodule
